vscale_htif_pcr_host: RTL and testbench

VSCALE_HTIF_PCR_HOST -- requirements
Module: vscale_htif_pcr_host

---
 rtl/vscale_htif_pcr_host_pkg.sv | 14 +
 rtl/vscale_sync_fifo.sv | 45 ++++
 rtl/vscale_htif_pcr_host.sv | 121 ++++++++++++
 tb/tb_vscale_htif_pcr_host.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_htif_pcr_host_pkg.sv
// vscale_htif_pcr_host_pkg: shared HTIF PCR widths, FSM state encodings and command layout
package vscale_htif_pcr_host_pkg;
    localparam int HTIF_PCR_WIDTH = 64;
    localparam int CSR_ADDR_WIDTH = 12;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RSP  = 2'd3;
    typedef struct packed {
        logic                      rw;
        logic [CSR_ADDR_WIDTH-1:0] addr;
        logic [HTIF_PCR_WIDTH-1:0] data;
    } pcr_cmd_t;
endpackage

// File: rtl/vscale_sync_fifo.sv
// vscale_sync_fifo: synchronous power-of-two FIFO; push when full and pop when empty are ignored
module vscale_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic do_push, do_pop;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("vscale_sync_fifo: DEPTH must be a power of two >= 2");
    end

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = wr_q == rd_q;
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rdata   = mem_q[rd_q[AW-1:0]];

    // Advance read/write pointers; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
        end
    end

    // Storage is not reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/vscale_htif_pcr_host.sv
// vscale_htif_pcr_host: buffers host CSR commands and runs them one at a time over the HTIF PCR port
// Optional response timeout enabled by defining HTIF_PCR_TIMEOUT_EN.
module vscale_htif_pcr_host
    import vscale_htif_pcr_host_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_rw,
    input  logic [CSR_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [HTIF_PCR_WIDTH-1:0] cmd_data,
    output logic                      htif_pcr_req_valid,
    input  logic                      htif_pcr_req_ready,
    output logic                      htif_pcr_req_rw,
    output logic [CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr,
    output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
    input  logic                      htif_pcr_resp_valid,
    output logic                      htif_pcr_resp_ready,
    input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [HTIF_PCR_WIDTH-1:0] rsp_data,
    output logic                      rsp_err,
    output logic                      busy
);
    pcr_cmd_t cmd_in, head, req_q, req_d;
    logic [1:0] state_q, state_d;
    logic [HTIF_PCR_WIDTH-1:0] data_q, data_d;
    logic err_q, err_d, ready_q, full, empty, pop, timeout;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("vscale_htif_pcr_host: TIMEOUT_CYCLES must be 1..65535");
    end

    assign cmd_in = {cmd_rw, cmd_addr, cmd_data};

    vscale_sync_fifo #(
        .WIDTH($bits(pcr_cmd_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid && cmd_ready),
        .pop   (pop),
        .wdata (cmd_in),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

`ifdef HTIF_PCR_TIMEOUT_EN
    logic [15:0] cnt_q;
    assign timeout = cnt_q == 16'(TIMEOUT_CYCLES - 1);
    // Count WAIT cycles; the counter rests at zero elsewhere so it starts clean on WAIT entry.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= (state_q == ST_WAIT) ? cnt_q + 16'd1 : '0;
    end
`else
    assign timeout = 1'b0;
`endif

    // Sequence IDLE -> REQ -> WAIT -> RSP; a core response in the final WAIT cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: if (!empty) begin
                pop     = 1'b1;
                req_d   = head;
                state_d = ST_REQ;
            end
            ST_REQ: if (htif_pcr_req_ready) state_d = ST_WAIT;
            ST_WAIT: if (htif_pcr_resp_valid) begin
                data_d  = htif_pcr_resp_data;
                err_d   = 1'b0;
                state_d = ST_RSP;
            end else if (timeout) begin
                data_d  = '0;
                err_d   = 1'b1;
                state_d = ST_RSP;
            end
            default: if (rsp_ready) state_d = ST_IDLE;
        endcase
    end

    // Hold state, the in-flight request and the result; ready_q keeps cmd_ready low for a cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            err_q   <= err_d;
            ready_q <= 1'b1;
        end
    end

    assign cmd_ready           = ready_q && !full;
    assign htif_pcr_req_valid  = state_q == ST_REQ;
    assign htif_pcr_req_rw     = req_q.rw;
    assign htif_pcr_req_addr   = req_q.addr;
    assign htif_pcr_req_data   = req_q.data;
    assign htif_pcr_resp_ready = state_q == ST_WAIT;
    assign rsp_valid           = state_q == ST_RSP;
    assign rsp_data            = data_q;
    assign rsp_err             = err_q;
    assign busy                = !empty || state_q != ST_IDLE;
endmodule

// File: tb/tb_vscale_htif_pcr_host.sv
// tb_vscale_htif_pcr_host: scoreboard bench with a CSR core model and a stalling result consumer
module tb_vscale_htif_pcr_host;
    import vscale_htif_pcr_host_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [63:0] cmd_data = '0;
    logic htif_pcr_req_valid, htif_pcr_req_ready = 1'b0, htif_pcr_req_rw;
    logic [11:0] htif_pcr_req_addr;
    logic [63:0] htif_pcr_req_data;
    logic htif_pcr_resp_valid = 1'b0, htif_pcr_resp_ready;
    logic [63:0] htif_pcr_resp_data = '0;
    logic rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
    logic [63:0] rsp_data;

    int n_cmp = 0, n_err = 0, n_sent = 0, hs = 0, rsp_count = 0;
    int req_stall = 0, core_delay = 0, rsp_stall = 0;
    logic core_mute = 1'b0;
    logic [63:0] ref_csr [4096];
    logic [63:0] core_csr [4096];
    exp_t exp_q [$];

    vscale_htif_pcr_host #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk                 (clk),
        .reset               (reset),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_rw              (cmd_rw),
        .cmd_addr            (cmd_addr),
        .cmd_data            (cmd_data),
        .htif_pcr_req_valid  (htif_pcr_req_valid),
        .htif_pcr_req_ready  (htif_pcr_req_ready),
        .htif_pcr_req_rw     (htif_pcr_req_rw),
        .htif_pcr_req_addr   (htif_pcr_req_addr),
        .htif_pcr_req_data   (htif_pcr_req_data),
        .htif_pcr_resp_valid (htif_pcr_resp_valid),
        .htif_pcr_resp_ready (htif_pcr_resp_ready),
        .htif_pcr_resp_data  (htif_pcr_resp_data),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_data            (rsp_data),
        .rsp_err             (rsp_err),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) if (!reset && htif_pcr_req_valid && htif_pcr_req_ready) hs++;

    // kind 0: normal response expected, 1: timeout response expected, 2: no response expected
    task automatic send(input logic rw, input logic [11:0] addr, input logic [63:0] data, input int kind);
        int n = 0;
        exp_t e;
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_data = data;
        while (!cmd_ready && n < 500) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", 1'b0, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_sent++;
        if (kind == 0) begin
            e.err = 1'b0;
            if (rw) begin ref_csr[addr] = data; e.data = data; end
            else e.data = ref_csr[addr];
            exp_q.push_back(e);
        end else if (kind == 1) begin
            e.data = '0; e.err = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin @(posedge clk); #1; n++; end
        if (n >= 3000) check("idle_timeout", 1'b1, 1'b0);
    endtask

    task automatic reset_checks();
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_req_valid", htif_pcr_req_valid, 1'b0);
        check("rst_resp_ready", htif_pcr_resp_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 64'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_busy", busy, 1'b0);
    endtask

    // Core model: stalls req_ready, injects ignored responses while not in WAIT, then answers from its CSR file.
    initial begin
        logic r_rw;
        logic [11:0] r_addr;
        logic [63:0] r_data, rdata;
        forever begin
            @(posedge clk); #1;
            if (htif_pcr_req_valid && !reset) begin
                r_rw = htif_pcr_req_rw; r_addr = htif_pcr_req_addr; r_data = htif_pcr_req_data;
                for (int i = 0; i < req_stall; i++) begin
                    htif_pcr_resp_valid = 1'b1;
                    htif_pcr_resp_data = 64'hBAD0_BAD0_BAD0_BAD0;
                    @(posedge clk); #1;
                    check("req_stable", {htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data},
                          {1'b1, r_rw, r_addr, r_data});
                    check("resp_ready_outside_wait", htif_pcr_resp_ready, 1'b0);
                end
                htif_pcr_resp_valid = 1'b0;
                htif_pcr_req_ready = 1'b1;
                @(posedge clk); #1;
                htif_pcr_req_ready = 1'b0;
                rdata = r_rw ? r_data : core_csr[r_addr];
                if (r_rw) core_csr[r_addr] = r_data;
                repeat (core_delay) begin @(posedge clk); #1; end
                if (!core_mute) begin
                    int n = 0;
                    htif_pcr_resp_valid = 1'b1;
                    htif_pcr_resp_data = rdata;
                    while (!htif_pcr_resp_ready && n < 100) begin @(posedge clk); #1; n++; end
                    if (!htif_pcr_resp_ready) check("resp_ready_timeout", 1'b0, 1'b1);
                    @(posedge clk); #1;
                    htif_pcr_resp_valid = 1'b0;
                    htif_pcr_resp_data = '0;
                end
            end
        end
    end

    // Consumer: optionally stalls rsp_ready, checks the held result, then pops the scoreboard.
    initial begin
        logic [63:0] d;
        logic e;
        exp_t x;
        forever begin
            @(posedge clk); #1;
            if (rsp_valid && !reset) begin
                d = rsp_data; e = rsp_err;
                for (int i = 0; i < rsp_stall; i++) begin
                    @(posedge clk); #1;
                    check("rsp_stable", {rsp_valid, rsp_err, rsp_data}, {1'b1, e, d});
                    check("no_req_while_rsp", htif_pcr_req_valid, 1'b0);
                end
                rsp_ready = 1'b1;
                @(posedge clk); #1;
                rsp_ready = 1'b0;
                rsp_count++;
                if (exp_q.size() == 0) check("rsp_unexpected", 1'b1, 1'b0);
                else begin
                    x = exp_q.pop_front();
                    check("rsp_data", d, x.data);
                    check("rsp_err", e, x.err);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, seen;
        for (int i = 0; i < 4096; i++) begin
            ref_csr[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
            core_csr[i] = ref_csr[i];
        end
        ref_csr[12'h780] = 64'h1234;
        core_csr[12'h780] = 64'h1234;

        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        reset = 1'b0;
        check("ready_gap", cmd_ready, 1'b0);
        @(posedge clk); #1;
        check("ready_after_reset", cmd_ready, 1'b1);

        core_delay = 2;
        send(1'b0, 12'h780, 64'h0, 0);
        wait_idle();
        core_delay = 0;

        send(1'b1, 12'h341, 64'hDEAD_BEEF_CAFE_F00D, 0);
        send(1'b0, 12'h341, 64'h0, 0);
        wait_idle();

        req_stall = 5;
        send(1'b0, 12'h300, 64'h55, 0);
        wait_idle();

        req_stall = 20;
        for (int i = 0; i < 5; i++)
            send(1'($urandom_range(0, 1)), 12'h100 + 12'(i % 3), {$urandom, $urandom}, 0);
        check("fifo_full_ready", cmd_ready, 1'b0);
        check("busy_when_full", busy, 1'b1);
        req_stall = 0;
        send(1'b0, 12'h101, 64'h0, 0);
        wait_idle();

        rsp_stall = 10;
        send(1'b0, 12'h780, 64'h0, 0);
        wait_idle();
        rsp_stall = 0;

`ifdef HTIF_PCR_TIMEOUT_EN
        core_mute = 1'b1;
        send(1'b0, 12'h342, 64'h0, 1);
        n = 0; seen = 0;
        do begin
            @(posedge clk); #1;
            if (htif_pcr_resp_ready) seen++;
            n++;
        end while (!rsp_valid && n < 100);
        check("timeout_wait_cycles", seen, 8);
        wait_idle();
        core_mute = 1'b0;
`endif

        core_mute = 1'b1;
        send(1'b0, 12'h7C0, 64'h0, 2);
        n = 0;
        while (!htif_pcr_resp_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("reached_wait", htif_pcr_resp_ready, 1'b1);
        seen = rsp_count;
        reset = 1'b1;
        @(posedge clk); #1;
        reset_checks();
        reset = 1'b0;
        check("ready_gap_mid", cmd_ready, 1'b0);
        @(posedge clk); #1;
        check("ready_after_mid_reset", cmd_ready, 1'b1);
        core_mute = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("no_abandoned_rsp", rsp_count, seen);
        send(1'b0, 12'h780, 64'h0, 0);
        send(1'b1, 12'h7C0, 64'h0123_4567_89AB_CDEF, 0);
        wait_idle();

        check("handshakes", hs, n_sent);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
